// File: rtl/pic_sel_ctl.sv
// Picture-select controller: takes incr/decr commands, keeps a wrapping picture index and
// drives one load request per index change. Optional boot load via `PIC_SEL_BOOT_LOAD_EN`.
module pic_sel_ctl #(
    parameter int IDX_W   = 8,
    parameter int PIC_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctl_valid,
    output logic             ctl_ready,
    input  logic             ctl_incr,
    input  logic             ctl_decr,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic [IDX_W-1:0] ld_idx,
    input  logic             ld_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_REARM = 3'd4
`ifdef PIC_SEL_BOOT_LOAD_EN
        , S_BOOT = 3'd5
`endif
    } state_t;

`ifdef PIC_SEL_BOOT_LOAD_EN
    localparam state_t RST_STATE = S_BOOT;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    // PIC_CNT may equal 2^IDX_W, so only the last legal index is formed at IDX_W bits
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIC_CNT - 1);

    state_t           state, state_nxt;
    logic             chg, chg_nxt;
    logic [IDX_W-1:0] idx_step, idx_nxt;
    logic             ctl_ready_nxt, ld_valid_nxt;

    // State register; registered outputs are loaded from the output decode of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            chg       <= 1'b0;
            ld_idx    <= '0;
            ctl_ready <= 1'b0;
            ld_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            chg       <= chg_nxt;
            ld_idx    <= idx_nxt;
            ctl_ready <= ctl_ready_nxt;
            ld_valid  <= ld_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ctl_valid) state_nxt = S_ACK;
            S_ACK:   state_nxt = chg ? S_REQ : S_REARM;
            S_REQ:   if (ld_ready) state_nxt = ld_done ? S_REARM : S_WAIT;
            S_WAIT:  if (ld_done) state_nxt = S_REARM;
            S_REARM: if (!ctl_valid) state_nxt = S_IDLE;
`ifdef PIC_SEL_BOOT_LOAD_EN
            S_BOOT:  state_nxt = S_REQ;
`endif
            default: state_nxt = RST_STATE;
        endcase
    end

    // Wrapping step of the current index; the internal index lives in ld_idx itself
    always_comb begin
        idx_step = ld_idx;
        if (ctl_incr && !ctl_decr)
            idx_step = (ld_idx == LAST_IDX) ? '0 : ld_idx + IDX_W'(1);
        else if (ctl_decr && !ctl_incr)
            idx_step = (ld_idx == '0) ? LAST_IDX : ld_idx - IDX_W'(1);
    end

    always_comb begin
        idx_nxt       = ld_idx;
        chg_nxt       = chg;
        ctl_ready_nxt = (state_nxt == S_ACK);
        ld_valid_nxt  = (state_nxt == S_REQ);
        if (state == S_IDLE && ctl_valid) begin
            idx_nxt = idx_step;
            chg_nxt = ctl_incr ^ ctl_decr;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
